// File: rtl/req_encoder8.sv
// Sequential multi-hot to binary encoder: serves set request bits lowest-first over valid/ready.
// Optional REQ_ENC_MERGE_EN: a load while serving merges req into the pending vector.
module req_encoder8 #(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   served_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             accept;
  logic [N-1:0]     lowest_bit;
  logic [N-1:0]     remaining;
  logic [IDX_W-1:0] idx;

  assign busy       = (state_q == SERVE);
  assign out_valid  = busy;
  assign pending    = pending_q;
  assign done       = done_q;
  assign served_cnt = cnt_q;
  assign out_idx    = idx;

  assign accept     = out_valid & out_ready;
  // Two's-complement trick isolates the lowest set bit, i.e. the bit at out_idx.
  assign lowest_bit = pending_q & (~pending_q + N'(1));
  assign remaining  = accept ? (pending_q & ~lowest_bit) : pending_q;

  always_comb begin
    idx = '0;
    if (out_valid) begin
      for (int unsigned i = N; i > 0; i--) begin
        if (pending_q[i-1]) idx = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load && (req != '0)) begin
          pending_d = req;
          cnt_d     = '0;
          state_d   = SERVE;
        end
      end
      SERVE: begin
        if (accept) cnt_d = cnt_q + (IDX_W+1)'(1);
        pending_d = remaining;
`ifdef REQ_ENC_MERGE_EN
        if (load) pending_d = remaining | req;
`endif
        if (pending_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

endmodule
